qcore_reg_bank_mp: RTL

// Parametrised multi-port register bank for the qick tProcessor core: data regs, double-buffered wave regs, SFR page, LFSR.

---
 rtl/qcore_reg_bank_mp_if.sv | 13 +
 rtl/qcore_reg_bank_mp.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/qcore_reg_bank_mp_if.sv
// qcore_reg_bank_mp_if: read/write port bundle for the multi-port register bank.
interface qcore_reg_bank_mp_if #(
    parameter int RD_PORTS = 2,
    parameter int WR_PORTS = 2
);
    logic [WR_PORTS-1:0]       we;
    logic [WR_PORTS-1:0][6:0]  w_addr;
    logic [WR_PORTS-1:0][31:0] w_dt;
    logic [RD_PORTS-1:0][6:0]  rd_addr;
    logic [RD_PORTS-1:0][31:0] rd_dt;
    modport master (output we, w_addr, w_dt, rd_addr, input rd_dt);
    modport slave  (input we, w_addr, w_dt, rd_addr, output rd_dt);
endinterface

// File: rtl/qcore_reg_bank_mp.sv
// qcore_reg_bank_mp: multi-port register bank with data regs, double-buffered wave regs, SFR page and LFSR.
module qcore_reg_bank_mp #(
    parameter int DREG_AW   = 4,
    parameter int RD_PORTS  = 2,
    parameter int WR_PORTS  = 2,
    parameter int WAVE_REGS = 6,
    parameter int SFR_IN    = 9,
    parameter int LFSR_W    = 32,
    parameter int FWD       = 1
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        clear_i,
    input  logic [1:0]                                  lfsr_cfg_i,
    qcore_reg_bank_mp_if.slave                          bus,
    input  logic [(SFR_IN > 0 ? SFR_IN : 1)-1:0][31:0]  sfr_in_i,
    input  logic                                        wave_ld_i,
    input  logic [WAVE_REGS*32-1:0]                     wave_dt_i,
    input  logic                                        wave_commit_i,
    output logic [WAVE_REGS*32-1:0]                     wave_o,
    output logic [3:0][31:0]                            sreg_o,
    output logic [15:0]                                 cfg_o,
    output logic [31:0]                                 lfsr_o
);
    localparam int ND = 2**DREG_AW;
    logic [ND-1:0][31:0]       dreg_q, dreg_d;
    logic [ND-1:0]             dhit;
    logic [7:0][31:0]          wsh_q, wsh_d, wact_q, wact_d;
    logic [7:0]                whit;
    logic [3:0][31:0]          sreg_q, sreg_d;
    logic [3:0]                shit;
    logic [15:0]               cfg_q, cfg_d;
    logic                      chit, lhit, lstep_wr, lrd, lstep;
    logic [31:0]               lfsr_q, lfsr_d, lfsr_ld, lfsr_nx;
    logic [RD_PORTS-1:0][31:0] rd_q, rd_d;
    // Ports are scanned in ascending order so the highest-index writer wins.
    always_comb begin
        dreg_d = dreg_q;
        wsh_d = wsh_q;
        sreg_d = sreg_q;
        cfg_d = cfg_q;
        dhit = '0;
        whit = '0;
        shit = '0;
        chit = 1'b0;
        lhit = 1'b0;
        lstep_wr = 1'b0;
        lfsr_ld = lfsr_q;
        for (int k = 0; k < WAVE_REGS; k++)
            if (wave_ld_i) begin
                wsh_d[k] = wave_dt_i[32*k +: 32];
                whit[k] = 1'b1;
            end
        for (int p = 0; p < WR_PORTS; p++) begin
            logic [6:0]  wa;
            logic [31:0] wd;
            wa = bus.w_addr[p];
            wd = bus.w_dt[p];
            if (bus.we[p])
                case (wa[6:5])
                    2'b00: begin
                        dreg_d[wa[DREG_AW-1:0]] = wd;
                        dhit[wa[DREG_AW-1:0]] = 1'b1;
                    end
                    2'b01: if (wa[4:0] < 5'(WAVE_REGS)) begin
                        wsh_d[wa[2:0]] = wd;
                        whit[wa[2:0]] = 1'b1;
                    end
                    2'b10: begin
                        if (wa[4:0] == 5'd0) lstep_wr = 1'b1;
                        if (wa[4:0] == 5'd1) begin
                            lhit = 1'b1;
                            lfsr_ld = wd;
                        end
                        if (wa[4:0] == 5'd2) begin
                            chit = 1'b1;
                            cfg_d = wd[15:0];
                        end
                        if (wa[4:2] == 3'b011) begin
                            shit[wa[1:0]] = 1'b1;
                            sreg_d[wa[1:0]] = wd;
                        end
                    end
                    default: ;
                endcase
        end
        if (clear_i) begin
            dreg_d = '0;
            wsh_d = '0;
        end
        wact_d = clear_i ? '0 : wave_commit_i ? wsh_d : wact_q;
        lrd = 1'b0;
        for (int p = 0; p < RD_PORTS; p++) lrd |= bus.rd_addr[p] == 7'h41;
        lfsr_nx = LFSR_W == 32 ? {lfsr_q[30:0], ~(lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0])}
                               : {16'h0, lfsr_q[14:0], ~(lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3])};
        lstep = lfsr_cfg_i == 2'b01 || (lfsr_cfg_i == 2'b10 && lrd) || (lfsr_cfg_i == 2'b11 && lstep_wr);
        lfsr_d = lhit ? (LFSR_W == 32 ? lfsr_ld : {16'h0, lfsr_ld[15:0]}) : lstep ? lfsr_nx : lfsr_q;
    end
    // A written target forwards its next-state value when FWD is set.
    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            logic [6:0] ra;
            ra = bus.rd_addr[p];
            rd_d[p] = '0;
            case (ra[6:5])
                2'b00: rd_d[p] = (FWD != 0 && dhit[ra[DREG_AW-1:0]]) ? dreg_d[ra[DREG_AW-1:0]] : dreg_q[ra[DREG_AW-1:0]];
                2'b01: if (ra[4:0] < 5'(WAVE_REGS)) rd_d[p] = (FWD != 0 && whit[ra[2:0]]) ? wsh_d[ra[2:0]] : wsh_q[ra[2:0]];
                2'b10: begin
                    if (ra[4:0] == 5'd1) rd_d[p] = (FWD != 0 && lhit) ? lfsr_d : lfsr_q;
                    if (ra[4:0] == 5'd2) rd_d[p] = {16'h0, (FWD != 0 && chit) ? cfg_d : cfg_q};
                    for (int i = 0; i < SFR_IN; i++) if (ra[4:0] == 5'(i + 3)) rd_d[p] = sfr_in_i[i];
                    if (ra[4:2] == 3'b011) rd_d[p] = (FWD != 0 && shit[ra[1:0]]) ? sreg_d[ra[1:0]] : sreg_q[ra[1:0]];
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            dreg_q <= '0;
            wsh_q <= '0;
            wact_q <= '0;
            sreg_q <= '0;
            cfg_q <= '0;
            lfsr_q <= '0;
            rd_q <= '0;
        end else begin
            dreg_q <= dreg_d;
            wsh_q <= wsh_d;
            wact_q <= wact_d;
            sreg_q <= sreg_d;
            cfg_q <= cfg_d;
            lfsr_q <= lfsr_d;
            rd_q <= rd_d;
        end
    assign bus.rd_dt = rd_q;
    assign wave_o = wact_q[WAVE_REGS-1:0];
    assign sreg_o = sreg_q;
    assign cfg_o = cfg_q;
    assign lfsr_o = lfsr_q;
endmodule
